// File: rtl/pcpi_mem_arbiter_pkg.sv
// Shared types and constants for the two-master PicoRV32 native-bus arbiter.
package pcpi_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/pcpi_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick; on a tie the master other than `last` wins.
module pcpi_mem_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/pcpi_mem_arbiter.sv
// Two-master, one-slave arbiter for the PicoRV32 native memory interface with
// registered round-robin grant and a wait-state watchdog.
module pcpi_mem_arbiter
  import pcpi_mem_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT   = 16,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [1:0]       grant_nxt, pick;
  logic             last, last_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             terr_nxt;
  logic             forced;
  req_t             req0, req1;

  assign req0 = '{valid: m0_valid, instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign req1 = '{valid: m1_valid, instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  pcpi_mem_arbiter_rr_arb2 u_rr (
    .req  ({req1.valid, req0.valid}),
    .last (last),
    .pick (pick)
  );

  // Request fields pass through live from the latched owner.
  assign s_instr = grant[1] ? req1.instr : req0.instr;
  assign s_addr  = grant[1] ? req1.addr  : req0.addr;
  assign s_wdata = grant[1] ? req1.wdata : req0.wdata;
  assign s_wstrb = grant[1] ? req1.wstrb : req0.wstrb;

  // A real slave response in the watchdog's final cycle wins over the forced one.
  assign forced = (TIMEOUT != 0) && (state == BUSY) && !s_ready &&
                  (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last        <= last_nxt;
      wait_cnt    <= wait_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    wait_nxt  = wait_cnt;
    terr_nxt  = timeout_err;
    s_valid   = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;

    case (state)
      IDLE: begin
        if (pick != 2'b00) begin
          state_nxt = BUSY;
          grant_nxt = pick;
          wait_nxt  = '0;
        end
      end
      BUSY: begin
        s_valid  = !forced;
        m0_ready = grant[0] & (s_ready | forced);
        m1_ready = grant[1] & (s_ready | forced);
        if (forced) begin
          if (grant[1]) m1_rdata = ERR_RDATA;
          else          m0_rdata = ERR_RDATA;
        end
        if (s_ready || forced) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          last_nxt  = grant[1];
          wait_nxt  = '0;
          terr_nxt  = timeout_err | forced;
        end else if (wait_cnt != CNT_W'(TIMEOUT)) begin
          wait_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcpi_mem_arbiter.sv
// Self-checking bench for pcpi_mem_arbiter: directed and randomized transactions
// checked against a transaction-level latency/arbitration model.
module tb_pcpi_mem_arbiter;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  grant;
  logic        timeout_err;

  int   tests = 0;
  int   fails = 0;
  logic exp_terr = 1'b0;

  pcpi_mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    m0_valid = 0; m1_valid = 0; s_ready = 0;
  endtask

  task automatic set_master(input int m, input logic v, input logic ins,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (m == 0) begin
      m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    resetn = 0;
    drive_idle();
    repeat (n) @(posedge clk);
    #1 resetn = 1;
    exp_terr = 1'b0;
    @(negedge clk);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset s_valid", 32'(s_valid), 32'd0);
    chk("reset m0_ready", 32'(m0_ready), 32'd0);
    chk("reset m1_ready", 32'(m1_ready), 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
  endtask

  // One transaction from idle; slave answers after `lat` wait cycles.
  // Completion lands on BUSY cycle lat+1, or the watchdog forces it on cycle TO.
  task automatic run_txn(input int m, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int lat, input logic [31:0] rd);
    bit          err;
    int          c;
    logic        own_rdy, oth_rdy;
    logic [31:0] own_rd;
    err = (lat >= int'(TO));
    c   = err ? int'(TO) : lat + 1;
    @(posedge clk); #1;
    set_master(m, 1'b1, ins, a, wd, ws);
    s_ready = 0;
    @(negedge clk);
    chk("arb latency s_valid", 32'(s_valid), 32'd0);
    for (int k = 1; k <= c; k++) begin
      @(posedge clk); #1;
      s_ready = (k == lat + 1);
      s_rdata = (k == lat + 1) ? rd : $urandom;
      @(negedge clk);
      own_rdy = (m == 0) ? m0_ready : m1_ready;
      oth_rdy = (m == 0) ? m1_ready : m0_ready;
      own_rd  = (m == 0) ? m0_rdata : m1_rdata;
      if (k == 1) begin
        chk("grant owner", 32'(grant), (m == 0) ? 32'd1 : 32'd2);
        chk("s_addr pass", s_addr, a);
        chk("s_wdata pass", s_wdata, wd);
        chk("s_wstrb pass", 32'(s_wstrb), 32'(ws));
        chk("s_instr pass", 32'(s_instr), 32'(ins));
      end
      if (k < c) begin
        chk("ready while waiting", 32'(own_rdy), 32'd0);
        chk("s_valid while waiting", 32'(s_valid), 32'd1);
      end else begin
        chk("ready at completion", 32'(own_rdy), 32'd1);
        chk("rdata at completion", own_rd, err ? ERR : rd);
        chk("s_valid at completion", 32'(s_valid), err ? 32'd0 : 32'd1);
      end
      chk("other ready", 32'(oth_rdy), 32'd0);
    end
    @(posedge clk); #1;
    set_master(m, 1'b0, ins, a, wd, ws);
    s_ready = 0;
    if (err) exp_terr = 1'b1;
    @(negedge clk);
    chk("grant after done", 32'(grant), 32'd0);
    chk("s_valid after done", 32'(s_valid), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
  endtask

  initial begin
    int          prev, owner, cnt0, cnt1, m, lat;
    logic [31:0] rd_drv;

    do_reset(2);

    run_txn(0, 1'b0, 32'h100, 32'h0, 4'b0000, 2, 32'h1234_5678);
    run_txn(1, 1'b0, 32'h2000, 32'hA5A5_A5A5, 4'b0011, 1, $urandom);
    // slave answers on exactly the cycle the watchdog would fire
    run_txn(0, 1'b1, 32'h300, 32'h0, 4'b0000, int'(TO) - 1, 32'hCAFE_F00D);

    // both masters held valid, zero-wait slave: owners must alternate from m0
    do_reset(1);
    prev = 1; cnt0 = 0; cnt1 = 0;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        set_master(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'b0000);
        set_master(1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'b0000);
        s_ready = 1;
      end
      rd_drv  = $urandom;
      s_rdata = rd_drv;
      @(negedge clk);
      if (j % 2 == 1) begin
        chk("alt idle grant", 32'(grant), 32'd0);
        chk("alt idle s_valid", 32'(s_valid), 32'd0);
      end else begin
        owner = 1 - prev;
        prev  = owner;
        chk("alt grant", 32'(grant), (owner == 0) ? 32'd1 : 32'd2);
        chk("alt s_valid", 32'(s_valid), 32'd1);
        chk("alt s_addr", s_addr, (owner == 0) ? 32'h1000 : 32'h2000);
        chk("alt rdata", (owner == 0) ? m0_rdata : m1_rdata, rd_drv);
      end
      chk("alt ready exclusive", 32'(m0_ready & m1_ready), 32'd0);
      cnt0 += int'(m0_ready);
      cnt1 += int'(m1_ready);
    end
    chk("alt m0 completions", 32'(cnt0), 32'd2);
    chk("alt m1 completions", 32'(cnt1), 32'd2);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("alt end grant", 32'(grant), 32'd0);

    // watchdog: slave never answers, then the sticky flag must survive a good txn
    run_txn(0, 1'b0, 32'h400, 32'h0, 4'b0000, 100, 32'h0);
    run_txn(1, 1'b0, 32'h404, 32'h0, 4'b0000, 0, 32'h5555_AAAA);

    for (int i = 0; i < 12; i++) begin
      m   = int'($urandom_range(0, 1));
      lat = int'($urandom_range(0, 5));
      run_txn(m, 1'($urandom), $urandom, $urandom, 4'($urandom), lat, $urandom);
    end

    // reset in the middle of a BUSY transaction owned by m1
    @(posedge clk); #1;
    set_master(1, 1'b1, 1'b0, 32'h800, 32'h0, 4'b0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset busy grant", 32'(grant), 32'd2);
    @(posedge clk); #1;
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    exp_terr = 1'b0;
    set_master(0, 1'b1, 1'b0, 32'h900, 32'h0, 4'b0000);
    @(negedge clk);
    chk("midreset grant", 32'(grant), 32'd0);
    chk("midreset s_valid", 32'(s_valid), 32'd0);
    chk("midreset m0_ready", 32'(m0_ready), 32'd0);
    chk("midreset m1_ready", 32'(m1_ready), 32'd0);
    chk("midreset timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-reset m0 priority", 32'(grant), 32'd1);
    chk("post-reset s_addr", s_addr, 32'h900);
    @(posedge clk); #1;
    s_ready = 1;
    s_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("post-reset m0_ready", 32'(m0_ready), 32'd1);
    chk("post-reset m1_ready", 32'(m1_ready), 32'd0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
